// File: rtl/hamming_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hamming_dec_ctrl
// Brief    : SECDED decode sequencer. It reads 16-bit codewords, drives the
//            syndrome LUT, and writes corrected data plus status to memory.
//            Optional statistics counters: define HAMMING_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_dec_ctrl #(
    parameter int W         = 8,
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 0,
    parameter int DST_BASE  = 30
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         Start,
    output logic         Done,
    output logic         Busy,
    output logic [W-1:0] MemAddr,
    output logic         MemWrEn,
    output logic [W-1:0] MemWrData,
    input  logic [W-1:0] MemRdData,
    output logic [W-1:0] EntryReg,
    output logic [W-1:0] MuxReg,
    input  logic [W-1:0] Target,
    output logic [W-1:0] CorrCnt,
    output logic [W-1:0] DblCnt
);

    localparam int K_W = 7;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_CAPT  = 3'd3;
    localparam logic [2:0] S_CLASS = 3'd4;
    localparam logic [2:0] S_WR_LO = 3'd5;
    localparam logic [2:0] S_WR_HI = 3'd6;

    localparam logic [W-1:0]   C_SRC_BASE = W'(SRC_BASE);
    localparam logic [W-1:0]   C_DST_BASE = W'(DST_BASE);
    localparam logic [W-1:0]   C_ONE      = W'(1);
    localparam logic [K_W-1:0] C_LAST_IDX = K_W'(NUM_WORDS - 1);
    localparam logic [K_W-1:0] C_IDX_ONE  = K_W'(1);

    logic [2:0]     r_state;
    logic [2:0]     w_nextState;
    logic [K_W-1:0] r_wordIdx;
    logic [K_W-1:0] w_nextIdx;
    logic [W-1:0]   w_nextOff;

    logic           r_done;
    logic [W-1:0]   r_memAddr;
    logic           r_memWrEn;
    logic [W-1:0]   r_memWrData;
    logic [W-1:0]   r_entry;
    logic [W-1:0]   r_mux;
    logic [7:0]     r_codeLo;
    logic [15:0]    r_code;
    logic [10:0]    r_data;
    logic [1:0]     r_status;

    logic [15:0]    w_capCode;
    logic [3:0]     w_syn;
    logic           w_par;
    logic [10:0]    w_data;
    logic [10:0]    w_corrData;
    logic [1:0]     w_status;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_wordIdx;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_nextState = S_RD_LO;
                    w_nextIdx   = '0;
                end
            end
            S_RD_LO: w_nextState = S_RD_HI;
            S_RD_HI: w_nextState = S_CAPT;
            S_CAPT:  w_nextState = S_CLASS;
            S_CLASS: w_nextState = S_WR_LO;
            S_WR_LO: w_nextState = S_WR_HI;
            S_WR_HI: begin
                if (r_wordIdx == C_LAST_IDX) begin
                    w_nextState = S_IDLE;
                end else begin
                    w_nextState = S_RD_LO;
                    w_nextIdx   = r_wordIdx + C_IDX_ONE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Byte offset of the word the FSM is about to work on; address adds wrap mod 2^W.
    assign w_nextOff = W'({w_nextIdx, 1'b0});

    // The high byte is still on the read bus in CAPT, so the syndrome is formed from it directly.
    assign w_capCode = {MemRdData[7:0], r_codeLo};
    assign w_syn[0]  = ^(w_capCode & 16'hAAAA);
    assign w_syn[1]  = ^(w_capCode & 16'hCCCC);
    assign w_syn[2]  = ^(w_capCode & 16'hF0F0);
    assign w_syn[3]  = ^(w_capCode & 16'hFF00);
    assign w_par     = ^w_capCode;

    assign w_data = {r_code[15:9], r_code[7:5], r_code[3]};

    always_comb begin
        w_corrData = w_data;
        w_status   = 2'b10;
        if (Target == '0) begin
            w_status = 2'b00;
        end else if (Target <= W'(11)) begin
            w_status = 2'b01;
            for (int j = 0; j < 11; j++) begin
                if (Target == W'(j + 1)) begin
                    w_corrData[j] = ~w_data[j];
                end
            end
        end else if (Target == W'(12)) begin
            w_status = 2'b01;
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_wordIdx   <= '0;
            r_done      <= 1'b0;
            r_memAddr   <= '0;
            r_memWrEn   <= 1'b0;
            r_memWrData <= '0;
            r_entry     <= '0;
            r_mux       <= '0;
            r_codeLo    <= '0;
            r_code      <= '0;
            r_data      <= '0;
            r_status    <= '0;
        end else begin
            r_wordIdx <= w_nextIdx;
            r_memWrEn <= (w_nextState == S_WR_LO) || (w_nextState == S_WR_HI);

            if (r_state == S_IDLE && Start) begin
                r_done <= 1'b0;
            end else if (r_state == S_WR_HI && w_nextState == S_IDLE) begin
                r_done <= 1'b1;
            end

            case (w_nextState)
                S_RD_LO: r_memAddr <= C_SRC_BASE + w_nextOff;
                S_RD_HI: r_memAddr <= C_SRC_BASE + w_nextOff + C_ONE;
                S_WR_LO: r_memAddr <= C_DST_BASE + w_nextOff;
                S_WR_HI: r_memAddr <= C_DST_BASE + w_nextOff + C_ONE;
                default: r_memAddr <= r_memAddr;
            endcase

            if (r_state == S_RD_HI) begin
                r_codeLo <= MemRdData[7:0];
            end
            if (r_state == S_CAPT) begin
                r_code  <= w_capCode;
                r_entry <= W'(w_syn);
                r_mux   <= W'(w_par);
            end
            if (r_state == S_CLASS) begin
                r_data      <= w_corrData;
                r_status    <= w_status;
                r_memWrData <= W'(w_corrData[7:0]);
            end
            if (r_state == S_WR_LO) begin
                r_memWrData <= W'({r_status, 3'b000, r_data[10:8]});
            end
        end
    end

`ifdef HAMMING_STATS_EN
    logic [W-1:0] r_corrCnt;
    logic [W-1:0] r_dblCnt;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_corrCnt <= '0;
            r_dblCnt  <= '0;
        end else if (r_state == S_IDLE && Start) begin
            r_corrCnt <= '0;
            r_dblCnt  <= '0;
        end else if (r_state == S_CLASS) begin
            if (w_status == 2'b01 && r_corrCnt != '1) begin
                r_corrCnt <= r_corrCnt + C_ONE;
            end
            if (w_status == 2'b10 && r_dblCnt != '1) begin
                r_dblCnt <= r_dblCnt + C_ONE;
            end
        end
    end

    assign CorrCnt = r_corrCnt;
    assign DblCnt  = r_dblCnt;
`else
    assign CorrCnt = '0;
    assign DblCnt  = '0;
`endif

    assign Done      = r_done;
    assign Busy      = (r_state != S_IDLE);
    assign MemAddr   = r_memAddr;
    assign MemWrEn   = r_memWrEn;
    assign MemWrData = r_memWrData;
    assign EntryReg  = r_entry;
    assign MuxReg    = r_mux;

endmodule
`default_nettype wire

// File: tb/tb_hamming_dec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_dec_ctrl
// Brief    : Self-checking bench for hamming_dec_ctrl with memory, LUT and
//            reference decoder models. Honours HAMMING_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_dec_ctrl;

    localparam int W   = 8;
    localparam int NW  = 15;
    localparam int SRC = 0;
    localparam int DST = 30;
    localparam logic [7:0] SENTINEL = 8'hA5;
    localparam int DATA_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef struct packed {
        logic [3:0]  syn;
        logic        par;
        logic [1:0]  status;
        logic [10:0] data;
    } refT;

    logic         Clk = 1'b0;
    logic         ResetN;
    logic         Start;
    logic         Done;
    logic         Busy;
    logic [W-1:0] MemAddr;
    logic         MemWrEn;
    logic [W-1:0] MemWrData;
    logic [W-1:0] MemRdData = '0;
    logic [W-1:0] EntryReg;
    logic [W-1:0] MuxReg;
    logic [W-1:0] Target;
    logic [W-1:0] CorrCnt;
    logic [W-1:0] DblCnt;

    logic [7:0]   mem [256];
    int           wrCount = 0;
    logic         badLut = 1'b0;
    logic [15:0]  cws [NW];
    logic [7:0]   entryQ [$];
    logic [7:0]   muxQ [$];
    int           nAssert = 0;
    int           nFail = 0;

    hamming_dec_ctrl #(
        .W(W), .NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST)
    ) dut (
        .Clk(Clk), .ResetN(ResetN), .Start(Start), .Done(Done), .Busy(Busy),
        .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData),
        .MemRdData(MemRdData), .EntryReg(EntryReg), .MuxReg(MuxReg),
        .Target(Target), .CorrCnt(CorrCnt), .DblCnt(DblCnt)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (MemWrEn) begin
            mem[MemAddr] <= MemWrData;
            wrCount      <= wrCount + 1;
        end
        MemRdData <= mem[MemAddr];
    end

    always @(negedge Clk) begin
        if (ResetN && MemWrEn && ((MemAddr - 8'(DST)) & 8'h01) == 8'h00) begin
            entryQ.push_back(EntryReg);
            muxQ.push_back(MuxReg);
        end
    end

    // Syndrome LUT: position of a single error mapped to its data index, 12/13 otherwise.
    function automatic logic [7:0] lut(input logic [3:0] syn, input logic par, input logic bad);
        if (!par && syn == 4'd0) return 8'd0;
        if (!par) return bad ? (8'hF0 | {4'h0, syn}) : 8'd13;
        for (int j = 0; j < 11; j++) begin
            if (DATA_POS[j] == int'(syn)) return 8'(j + 1);
        end
        return 8'd12;
    endfunction

    assign Target = lut(EntryReg[3:0], MuxReg[0], badLut);

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw;
        int s;
        cw = '0;
        s  = 0;
        for (int j = 0; j < 11; j++) cw[DATA_POS[j]] = d[j];
        for (int i = 1; i < 16; i++) if (cw[i]) s = s ^ i;
        for (int b = 0; b < 4; b++) if (s[b]) cw[1 << b] = 1'b1;
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic refT refDecode(input logic [15:0] cw);
        refT r;
        int s;
        s = 0;
        for (int i = 1; i < 16; i++) if (cw[i]) s = s ^ i;
        r.syn = 4'(s);
        r.par = ^cw;
        for (int j = 0; j < 11; j++) r.data[j] = cw[DATA_POS[j]];
        if (s == 0 && !r.par) begin
            r.status = 2'd0;
        end else if (r.par) begin
            r.status = 2'd1;
            for (int j = 0; j < 11; j++) if (DATA_POS[j] == s) r.data[j] = ~r.data[j];
        end else begin
            r.status = 2'd2;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic loadWords(input bit directed);
        logic [15:0] cw;
        int a;
        int b;
        for (int k = 0; k < NW; k++) begin
            cw = encode(11'($urandom));
            if (directed && k == 0) cw = 16'h0000;
            else if (directed && k == 1) cw = 16'h0020;
            else if (directed && k == 2) cw = 16'h0001;
            else if (directed && k == 3) cw = 16'h0028;
            else begin
                a = int'($urandom_range(0, 15));
                b = (a + int'($urandom_range(1, 15))) % 16;
                case ($urandom_range(0, 3))
                    1: cw[a] = ~cw[a];
                    2: begin cw[a] = ~cw[a]; cw[b] = ~cw[b]; end
                    default: ;
                endcase
            end
            cws[k] = cw;
            mem[8'(SRC + 2 * k)]     = cw[7:0];
            mem[8'(SRC + 2 * k + 1)] = cw[15:8];
        end
        for (int i = 0; i < 2 * NW; i++) mem[8'(DST + i)] = SENTINEL;
    endtask

    task automatic runAndCheck(input bit pokeStart);
        int cycles;
        int wr0;
        int expCorr;
        int expDbl;
        bit seen;
        refT r;
        entryQ.delete();
        muxQ.delete();
        wr0 = wrCount;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        check("done_clr_on_start", 32'(Done), 0);
        check("busy_in_run", 32'(Busy), 1);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 2000) begin
            @(posedge Clk);
            cycles++;
            #1;
            if (Done) seen = 1'b1;
            if (pokeStart && cycles == 20) Start = 1'b1;
            if (pokeStart && cycles == 21) Start = 1'b0;
        end
        check("run_len", 32'(cycles), 32'(6 * NW));
        check("done_end", 32'(Done), 1);
        check("busy_end", 32'(Busy), 0);
        check("wren_end", 32'(MemWrEn), 0);
        check("write_count", 32'(wrCount - wr0), 32'(2 * NW));
        check("entry_count", 32'(entryQ.size()), 32'(NW));
        expCorr = 0;
        expDbl  = 0;
        for (int k = 0; k < NW; k++) begin
            r = refDecode(cws[k]);
            if (r.status == 2'd1) expCorr++;
            if (r.status == 2'd2) expDbl++;
            check($sformatf("out_lo[%0d]", k), 32'(mem[8'(DST + 2 * k)]), 32'(r.data[7:0]));
            check($sformatf("out_hi[%0d]", k), 32'(mem[8'(DST + 2 * k + 1)]),
                  32'({r.status, 3'b000, r.data[10:8]}));
            if (k < entryQ.size()) begin
                check($sformatf("entry[%0d]", k), 32'(entryQ[k]), 32'({4'h0, r.syn}));
                check($sformatf("mux[%0d]", k), 32'(muxQ[k]), 32'({7'h0, r.par}));
            end
        end
`ifdef HAMMING_STATS_EN
        check("corr_cnt", 32'(CorrCnt), 32'(expCorr));
        check("dbl_cnt", 32'(DblCnt), 32'(expDbl));
`else
        check("corr_cnt", 32'(CorrCnt), 0);
        check("dbl_cnt", 32'(DblCnt), 0);
`endif
    endtask

    task automatic resetMidRun();
        int cycles;
        int sent;
        refT r;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        cycles = 0;
        while (!(MemWrEn && MemAddr == 8'(DST + 4)) && cycles < 200) begin
            @(negedge Clk);
            cycles++;
        end
        check("reach_wr_lo_w2", 32'(cycles < 200), 1);
        #1 ResetN = 1'b0;
        #1;
        check("rst_wren_async", 32'(MemWrEn), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_done", 32'(Done), 0);
        check("rst_addr", 32'(MemAddr), 0);
        repeat (5) @(negedge Clk);
        check("rst_done_hold", 32'(Done), 0);
        for (int k = 0; k < 2; k++) begin
            r = refDecode(cws[k]);
            check($sformatf("kept_lo[%0d]", k), 32'(mem[8'(DST + 2 * k)]), 32'(r.data[7:0]));
            check($sformatf("kept_hi[%0d]", k), 32'(mem[8'(DST + 2 * k + 1)]),
                  32'({r.status, 3'b000, r.data[10:8]}));
        end
        sent = 0;
        for (int i = 4; i < 2 * NW; i++) if (mem[8'(DST + i)] == SENTINEL) sent++;
        check("no_write_after_rst", 32'(sent), 32'(2 * NW - 4));
        ResetN = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        ResetN = 1'b0;
        Start  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge Clk);
        check("reset_done", 32'(Done), 0);
        check("reset_busy", 32'(Busy), 0);
        check("reset_addr", 32'(MemAddr), 0);
        check("reset_wren", 32'(MemWrEn), 0);
        check("reset_wrdata", 32'(MemWrData), 0);
        check("reset_entry", 32'(EntryReg), 0);
        check("reset_mux", 32'(MuxReg), 0);
        check("reset_corr", 32'(CorrCnt), 0);
        check("reset_dbl", 32'(DblCnt), 0);
        ResetN = 1'b1;
        @(negedge Clk);

        // Directed words 0..3 first, with a Start pulse injected mid-run.
        loadWords(1'b1);
        runAndCheck(1'b1);
        check("tp_clean_lo", 32'(mem[8'(DST)]), 32'h00);
        check("tp_clean_hi", 32'(mem[8'(DST + 1)]), 32'h00);
        check("tp_single_lo", 32'(mem[8'(DST + 2)]), 32'h00);
        check("tp_single_hi", 32'(mem[8'(DST + 3)]), 32'h40);
        check("tp_par_hi", 32'(mem[8'(DST + 5)]), 32'h40);
        check("tp_dbl_lo", 32'(mem[8'(DST + 6)]), 32'h03);
        check("tp_dbl_hi", 32'(mem[8'(DST + 7)]), 32'h80);
        check("tp_entry_q", 32'(entryQ.size() > 3), 1);
        if (entryQ.size() > 3) begin
            check("tp_single_entry", 32'(entryQ[1]), 32'h05);
            check("tp_single_mux", 32'(muxQ[1]), 32'h01);
            check("tp_par_mux", 32'(muxQ[2]), 32'h01);
            check("tp_dbl_entry", 32'(entryQ[3]), 32'h06);
            check("tp_dbl_mux", 32'(muxQ[3]), 32'h00);
        end

        // Out-of-range LUT results for double errors must still decode as double.
        badLut = 1'b1;
        loadWords(1'b0);
        runAndCheck(1'b0);
        badLut = 1'b0;

        loadWords(1'b0);
        resetMidRun();
        runAndCheck(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_dec_ctrl.md
# hamming_dec_ctrl

Sequencer for the Hamming SECDED decode program. Walks a block of 16-bit codewords in data memory, computes syndrome and overall parity per word, drives the external syndrome LUT (`EntryReg`/`MuxReg` -> `Target`), corrects the indicated data bit, and writes the 11-bit result plus a 2-bit status back to data memory. Sits between the top-level start/done handshake, the single-port data memory and the LUT instance.

## Interface

- `W`, 8: data/address path width.
- `NUM_WORDS`, 15: codewords per run, 1..127.
- `SRC_BASE`, 0: byte address of the first input codeword.
- `DST_BASE`, 30: byte address of the first output word.

- `Clk` in 1: single clock, rising edge.
- `ResetN` in 1: asynchronous, active-low reset.
- `Start` in 1: one-cycle pulse; honoured only in IDLE.
- `Done` out 1: high in IDLE after a completed run; cleared by `Start`.
- `Busy` out 1: high in every state except IDLE.
- `MemAddr` out W: data memory byte address.
- `MemWrEn` out 1: data memory write enable.
- `MemWrData` out W: data memory write data.
- `MemRdData` in W: data memory read data, valid the cycle after `MemAddr` is driven.
- `EntryReg` out W: to LUT, `{4'b0, syndrome[3:0]}`.
- `MuxReg` out W: to LUT, `{7'b0, overall_parity}`.
- `Target` in W: LUT result, combinational.
- `CorrCnt` out W: count of corrected words (see Configuration).
- `DblCnt` out W: count of double-error words (see Configuration).

## Operation

- Codeword k: low byte at `SRC_BASE+2k`, high byte at `SRC_BASE+2k+1`. Bit 0 is the overall parity p0. Bits 1..15 are Hamming positions 1..15. Parity bits sit at 1, 2, 4 and 8. Data bits d1..d11 sit at positions 3, 5, 6, 7, 9..15.
- Syndrome bit j is the XOR of all positions i in 1..15 with bit j of i set. `overall_parity` is the XOR of all 16 bits.
- Target decode:
  - 0: clean, status 00.
  - 1..11: flip data bit d[Target], status 01.
  - 12: parity-only error, data unchanged, status 01.
  - 13: double error, data passed uncorrected, status 10.
  - Any other value: treated as 13.
- Output for word k:
  - `DST_BASE+2k` receives d8..d1 (d1 at bit 0).
  - `DST_BASE+2k+1` receives `{status[1:0], 3'b000, d11..d9}`.
- FSM states: IDLE, RD_LO, RD_HI, CAPT, CLASS, WR_LO, WR_HI.
  - IDLE -> RD_LO on `Start`. Clears `Done`, resets word index k to 0.
  - RD_LO: `MemAddr`=src lo.
  - RD_HI: `MemAddr`=src hi; capture lo byte.
  - CAPT: capture hi byte.
  - CLASS: `EntryReg`/`MuxReg` valid; sample `Target`; register corrected data and status.
  - WR_LO, WR_HI: `MemWrEn`=1 with the output bytes.
  - WR_HI -> RD_LO with k+1 if k<NUM_WORDS-1. Otherwise -> IDLE with `Done`=1.
- Address arithmetic is modulo 2^W; wrap-around is permitted and not flagged.
- `Start` while `Busy` is ignored.

## Timing

- Reset values: state IDLE, `Done`=0, `Busy`=0, `MemAddr`=0, `MemWrEn`=0, `MemWrData`=0, `EntryReg`=0, `MuxReg`=0, `CorrCnt`=0, `DblCnt`=0, k=0.
- `EntryReg` and `MuxReg` are registered, hold their value outside CLASS, and change only on entry to CLASS.
- `MemWrEn` is high in WR_LO and WR_HI only. It is never high in any other state, including the reset cycle.
- Per word: 6 cycles. `Start` sampled at edge 0 gives `Done` high after edge 6·NUM_WORDS.
- Reset asserted mid-run: immediate return to IDLE. No further writes occur; already-written words stay in memory. `Done` stays 0.

## Configuration

- `HAMMING_STATS_EN` defined:
  - `CorrCnt` increments in CLASS for status 01.
  - `DblCnt` increments in CLASS for status 10.
  - Both saturate at 2^W-1 and clear on `Start`.
- `HAMMING_STATS_EN` undefined: counters are not built and `CorrCnt`/`DblCnt` are tied to 0. All other behaviour is identical.

## Test plan

- Clean word: codeword 0x0000 at src word 0 -> LUT sees Entry 0x00 / Mux 0x00; writes 0x00, 0x00; `Done` after 6·NUM_WORDS cycles.
- Single data error: codeword 0x0020 (position 5, d2 flipped) -> Entry 0x05 / Mux 0x01; Target 2; writes 0x00, 0x40; `CorrCnt`=1 with `HAMMING_STATS_EN`.
- Parity-only error: codeword 0x0001 -> Entry 0x00 / Mux 0x01; Target 12; writes 0x00, 0x40.
- Double error: codeword 0x0028 (positions 3, 5) -> Entry 0x06 / Mux 0x00; Target 13; writes 0x03, 0x80; `DblCnt`=1.
- Control:
  - `Start` pulsed while `Busy` -> ignored; run length unchanged.
  - `ResetN` low during WR_LO of word 2 -> `MemWrEn` drops asynchronously; FSM in IDLE; `Done`=0.
  - A new `Start` reruns from word 0.
- Full run, NUM_WORDS=15, mixed error pattern -> 30 writes at `DST_BASE`..`DST_BASE`+29, all matching a golden model; `Done`=1, `Busy`=0 afterwards.
